// File: rtl/shift_pkg.sv
// Shared FSM state and operation-code encodings for the multi-cycle shifter.
package shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        MODE_SLL = 3'b000,
        MODE_SRL = 3'b001,
        MODE_SRA = 3'b010,
        MODE_ROL = 3'b011,
        MODE_ROR = 3'b100
    } mode_e;

    // Codes above ROR are reserved and pass the operand through untouched.
    function automatic logic mode_is_reserved(input logic [2:0] mode);
        return mode > MODE_ROR;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves the operand by 0..STEP positions.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic [2:0]       mode_i,
    input  logic             sign_i,
    output logic [WIDTH-1:0] data_o
);

    logic [2*WIDTH-1:0] ext;
    logic [2*WIDTH-1:0] dbl;

    always_comb begin
        // sign_i is the MSB of the original operand, so repeated steps keep the fill consistent
        ext    = {{WIDTH{sign_i}}, data_i};
        dbl    = {data_i, data_i};
        data_o = data_i;
        case (mode_i)
            MODE_SLL: data_o = data_i << amt_i;
            MODE_SRL: data_o = data_i >> amt_i;
            MODE_SRA: data_o = WIDTH'(ext >> amt_i);
            MODE_ROL: data_o = WIDTH'((dbl << amt_i) >> WIDTH);
            MODE_ROR: data_o = WIDTH'(dbl >> amt_i);
            default:  data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shifter_multi_cycle.sv
// Iterative shifter: accepts one request, shifts up to STEP bits per cycle, holds the result until taken.
module shifter_multi_cycle
    import shift_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int STEP    = 1,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [2:0]         mode_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH-1:0]   data_o
);

    localparam int AMT_W = $clog2(STEP + 1);

    state_e             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [2:0]         mode_q, mode_d;
    logic               sign_q, sign_d;
    logic [AMT_W-1:0]   step_amt;
    logic [WIDTH-1:0]   step_res;

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .AMT_W (AMT_W)
    ) u_step (
        .data_i (work_q),
        .amt_i  (step_amt),
        .mode_i (mode_q),
        .sign_i (sign_q),
        .data_o (step_res)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        mode_d   = mode_q;
        sign_d   = sign_q;
        step_amt = (cnt_q > SHAMT_W'(STEP)) ? AMT_W'(STEP) : AMT_W'(cnt_q);
        ready_o  = (state_q == ST_IDLE);
        valid_o  = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    work_d  = data_i;
                    mode_d  = mode_i;
                    sign_d  = data_i[WIDTH-1];
                    // Reserved codes take the shamt=0 path: one pass-through BUSY cycle
                    cnt_d   = mode_is_reserved(mode_i) ? '0 : shamt_i;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                work_d = step_res;
                if (cnt_q > SHAMT_W'(STEP)) begin
                    cnt_d = cnt_q - SHAMT_W'(STEP);
                end else begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            mode_q  <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
        end
    end

    assign data_o = work_q;

endmodule

// File: tb/tb_shifter_multi_cycle.sv
// Randomized bench for shifter_multi_cycle with one STEP=1 and one STEP=4 instance.
module tb_shifter_multi_cycle;

    localparam int W = 64;

    logic        clk;
    logic        rst;
    logic        vld_i  [2];
    logic        rdy_o  [2];
    logic [63:0] din    [2];
    logic [5:0]  sh     [2];
    logic [2:0]  md     [2];
    logic        vld_o  [2];
    logic        rdy_i  [2];
    logic [63:0] dout   [2];

    int checks = 0;
    int errors = 0;

    shifter_multi_cycle #(.WIDTH(W), .STEP(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(vld_i[0]), .ready_o(rdy_o[0]),
        .data_i(din[0]), .shamt_i(sh[0]), .mode_i(md[0]), .valid_o(vld_o[0]),
        .ready_i(rdy_i[0]), .data_o(dout[0])
    );

    shifter_multi_cycle #(.WIDTH(W), .STEP(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .valid_i(vld_i[1]), .ready_o(rdy_o[1]),
        .data_i(din[1]), .shamt_i(sh[1]), .mode_i(md[1]), .valid_o(vld_o[1]),
        .ready_i(rdy_i[1]), .data_o(dout[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int step_of(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    // Reference result straight from the operation definitions
    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int s, input logic [2:0] m);
        logic [63:0] r;
        case (m)
            3'd0: r = d << s;
            3'd1: r = d >> s;
            3'd2: r = $signed(d) >>> s;
            3'd3: r = (s == 0) ? d : ((d << s) | (d >> (64 - s)));
            3'd4: r = (s == 0) ? d : ((d >> s) | (d << (64 - s)));
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic int ref_busy(input int s, input int step, input logic [2:0] m);
        if (m > 3'd4 || s == 0) return 1;
        return (s + step - 1) / step;
    endfunction

    task automatic scramble(input int u);
        vld_i[u] = 1'($urandom_range(0, 1));
        din[u]   = {$urandom, $urandom};
        sh[u]    = 6'($urandom);
        md[u]    = 3'($urandom);
    endtask

    // Latency counts rising edges from the accepting edge (inclusive) to the first edge with valid_o seen.
    task automatic run_op(input int u, input logic [63:0] d, input int s, input logic [2:0] m, input int hold);
        logic [63:0] exp_data;
        logic [63:0] held;
        int lat;
        int exp_lat;
        exp_data = ref_shift(d, s, m);
        exp_lat  = ref_busy(s, step_of(u), m) + 1;
        @(negedge clk);
        check_eq("ready_idle", 64'(rdy_o[u]), 64'd1);
        vld_i[u] = 1'b1;
        din[u]   = d;
        sh[u]    = 6'(s);
        md[u]    = m;
        @(posedge clk);
        lat = 1;
        #1;
        check_eq("ready_busy", 64'(rdy_o[u]), 64'd0);
        scramble(u);
        while (!vld_o[u] && lat < 300) begin
            @(posedge clk);
            lat++;
            #1;
            scramble(u);
        end
        check_eq("latency", 64'(lat), 64'(exp_lat));
        check_eq("result", dout[u], exp_data);
        held = dout[u];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            scramble(u);
            check_eq("hold_valid", 64'(vld_o[u]), 64'd1);
            check_eq("hold_data", dout[u], held);
        end
        vld_i[u] = 1'b0;
        rdy_i[u] = 1'b1;
        @(posedge clk);
        #1;
        rdy_i[u] = 1'b0;
        check_eq("release_ready", 64'(rdy_o[u]), 64'd1);
        check_eq("release_valid", 64'(vld_o[u]), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            vld_i[u] = 1'b0;
            din[u]   = '0;
            sh[u]    = '0;
            md[u]    = '0;
            rdy_i[u] = 1'b0;
        end
        rst = 1'b1;
        #3;
        for (int u = 0; u < 2; u++) begin
            check_eq("rst_ready", 64'(rdy_o[u]), 64'd1);
            check_eq("rst_valid", 64'(vld_o[u]), 64'd0);
            check_eq("rst_data", dout[u], 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        run_op(0, 64'h0000_0000_0000_0001, 63, 3'b000, 0);
        run_op(1, 64'h8000_0000_0000_0000, 5, 3'b010, 0);
        run_op(0, 64'h0000_0000_0000_0003, 1, 3'b100, 0);
        for (int m = 0; m < 8; m++) begin
            run_op(0, 64'hDEAD_BEEF_0123_4567, 0, 3'(m), 0);
            run_op(1, 64'hF0E1_D2C3_B4A5_9687, 63, 3'(m), 0);
        end
        run_op(0, 64'h1234_5678_9ABC_DEF0, 7, 3'b110, 0);
        run_op(1, 64'hA5A5_0000_FFFF_1234, 9, 3'b001, 10);

        // Asynchronous reset between edges while busy
        @(negedge clk);
        vld_i[0] = 1'b1;
        din[0]   = 64'hFFFF_0000_FFFF_0000;
        sh[0]    = 6'd40;
        md[0]    = 3'b000;
        @(posedge clk);
        #1;
        vld_i[0] = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("midrst_ready", 64'(rdy_o[0]), 64'd1);
        check_eq("midrst_valid", 64'(vld_o[0]), 64'd0);
        check_eq("midrst_data", dout[0], 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        check_eq("aborted_valid", 64'(vld_o[0]), 64'd0);
        run_op(0, 64'h0000_0000_0000_00F1, 4, 3'b011, 2);

        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, 1)), {$urandom, $urandom},
                   int'($urandom_range(0, 63)), 3'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shifter_multi_cycle.md
SHIFTER_MULTI_CYCLE -- requirements
Module: Shifter_Multi_Cycle

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data width in bits (power of two, 8..128).
REQ-002 SHALL have parameter STEP, default 1, maximum bit positions shifted per cycle (power of two, 1..WIDTH/2).
REQ-003 SHALL derive localparam SHAMT_W = clog2(WIDTH).
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port valid_i  input  1  request valid.
REQ-007 SHALL have port ready_o  output  1  block can accept a request.
REQ-008 SHALL have port data_i  input  WIDTH  operand.
REQ-009 SHALL have port shamt_i  input  SHAMT_W  shift amount, 0..WIDTH-1.
REQ-010 SHALL have port mode_i  input  3  operation code.
REQ-011 SHALL have port valid_o  output  1  result valid.
REQ-012 SHALL have port ready_i  input  1  consumer accepts result.
REQ-013 SHALL have port data_o  output  WIDTH  result.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 SHALL assert ready_o only in IDLE; valid_o only in DONE.
REQ-016 SHALL accept a request on a rising edge with valid_i=1 and ready_o=1, latching data_i, shamt_i, mode_i, and moving to BUSY.
REQ-017 SHALL ignore valid_i and input changes while in BUSY or DONE.
REQ-018 In BUSY with remaining count cnt: if cnt>STEP, shift working register by STEP and set cnt-=STEP; else shift by cnt, set cnt=0, go to DONE.
REQ-019 SHALL spend max(1, ceil(shamt/STEP)) cycles in BUSY; shamt=0 spends exactly one BUSY cycle with no shift.
REQ-020 SHALL raise valid_o max(1, ceil(shamt/STEP))+1 cycles after the accepting edge.
REQ-021 SHALL hold data_o and valid_o stable in DONE until ready_i=1, then go to IDLE on that edge.
REQ-022 SHALL not accept a new request in the DONE->IDLE cycle; minimum request spacing is BUSY cycles + 2.
REQ-023 Mode 000 SLL: zero fill from LSB.
REQ-024 Mode 001 SRL: zero fill from MSB.
REQ-025 Mode 010 SRA: fill with bit WIDTH-1 of the latched operand.
REQ-026 Mode 011 ROL; mode 100 ROR; rotation modulo WIDTH, no bits lost.
REQ-027 Modes 101-111 reserved: result equals latched operand unchanged, same timing as shamt=0.
REQ-028 data_o SHALL equal the working register; its value outside DONE is don't-care for consumers.

Reset
REQ-029 rst_i=1 SHALL immediately force state IDLE, ready_o=1, valid_o=0, data_o=0, cnt=0, independent of clk_i.
REQ-030 Reset in BUSY or DONE SHALL abort the operation with no result delivered.
REQ-031 First acceptance after reset deassertion SHALL occur no earlier than the first rising edge with rst_i=0.

Structure
REQ-032 Mode codes and FSM state encodings SHALL live in shared package shift_pkg.
REQ-033 Sub-module Shift_Step SHALL be the combinational single-step shifter (operand, amount 0..STEP, mode, sign) -> result; top holds FSM, counter and registers.

Verification
REQ-034 WIDTH=64, STEP=1: SLL data=0x0000_0000_0000_0001, shamt=63 -> valid_o 64 cycles after accept, data_o=0x8000_0000_0000_0000.
REQ-035 WIDTH=64, STEP=4: SRA data=0x8000_0000_0000_0000, shamt=5 -> 2 BUSY cycles, valid_o 3 cycles after accept, data_o=0xFC00_0000_0000_0000.
REQ-036 WIDTH=64, STEP=1: ROR data=0x0000_0000_0000_0003, shamt=1 -> data_o=0x8000_0000_0000_0001; shamt=0 any mode -> data_o=data_i after 2 cycles.
REQ-037 Backpressure: hold ready_i=0 for 10 cycles in DONE -> valid_o and data_o stable; new valid_i pulses during BUSY and DONE ignored.
REQ-038 Assert rst_i mid-BUSY between edges -> ready_o=1, valid_o=0 and data_o=0 immediately; next request completes correctly.
REQ-039 Mode 110, data=0x1234_5678_9ABC_DEF0, shamt=7 -> data_o=0x1234_5678_9ABC_DEF0 after 2 cycles.
